// File: rtl/cm0_dap_cdc_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cm0_dap_cdc_req_ctrl
// Description : Source-side controller for a 4-phase REQ/ACK clock-domain
//               crossing. Captures a payload, holds it stable and sequences
//               the mask enable / REQ against a synchronised ACK so that the
//               downstream AND-gate mask cells only pass stable data.
// Revision    : 1.0 - initial release
// ============================================================================
module cm0_dap_cdc_req_ctrl #(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PRESENT     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          txvalid,
    input  logic [DW-1:0] txdata,
    output logic          txready,
    output logic          txdone,
    output logic [DW-1:0] dataout,
    output logic          maskn,
    output logic          reqout,
    input  logic          ackin,
    output logic          busy
);

    generate
        if (PRESENT != 0) begin : g_present

            typedef enum logic [1:0] {
                ST_IDLE    = 2'd0,
                ST_SETUP   = 2'd1,
                ST_REQ     = 2'd2,
                ST_ACKWAIT = 2'd3
            } state_t;

            state_t                 r_state;
            state_t                 w_state_nxt;
            logic [SYNC_STAGES-1:0] r_ack_sync;
            logic [SYNC_STAGES-1:0] r_warm;
            logic [DW-1:0]          r_data;
            logic                   r_maskn;
            logic                   r_reqout;
            logic                   r_txdone;
            logic                   w_ack_s;
            logic                   w_txready;
            logic                   w_accept;
            logic                   w_req_nxt;
            logic                   w_done_nxt;

            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

            // The sync chain comes out of reset at 0 regardless of the real
            // ACK level; r_warm keeps the source from accepting until the
            // chain has been refilled, so a stale ACK left high across a
            // source reset is seen before any new transfer starts.
            assign w_txready = (r_state == ST_IDLE) && r_warm[SYNC_STAGES-1] && !w_ack_s;
            assign w_accept  = txvalid && w_txready;

            // ACK synchroniser chain and post-reset warm-up shifter
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ack_sync <= '0;
                    r_warm     <= '0;
                end else begin
                    r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ackin};
                    r_warm     <= {r_warm[SYNC_STAGES-2:0], 1'b1};
                end
            end

            // FSM state register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next-state and next-output decode for the 4-phase handshake
            always_comb begin
                w_state_nxt = r_state;
                w_req_nxt   = r_reqout;
                w_done_nxt  = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        w_req_nxt = 1'b0;
                        if (w_accept) begin
                            w_state_nxt = ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        // One full cycle of stable data before the mask opens
                        w_req_nxt   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                    ST_REQ: begin
                        if (w_ack_s) begin
                            w_req_nxt   = 1'b0;
                            w_state_nxt = ST_ACKWAIT;
                        end
                    end
                    ST_ACKWAIT: begin
                        w_req_nxt = 1'b0;
                        if (!w_ack_s) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            // Mask enable, REQ and completion pulse, all straight from flops
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_maskn  <= 1'b0;
                    r_reqout <= 1'b0;
                    r_txdone <= 1'b0;
                end else begin
                    r_maskn  <= w_req_nxt;
                    r_reqout <= w_req_nxt;
                    r_txdone <= w_done_nxt;
                end
            end

            // Payload register; only an accept may change it
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data <= '0;
                end else if (w_accept) begin
                    r_data <= txdata;
                end
            end

            assign txready = w_txready;
            assign txdone  = r_txdone;
            assign dataout = r_data;
            assign maskn   = r_maskn;
            assign reqout  = r_reqout;
            assign busy    = (r_state != ST_IDLE);

        end else begin : g_absent

            // Block not fitted: always ready, transfers are swallowed
            logic w_unused;
            assign w_unused = ^{clk, reset, txvalid, txdata, ackin};

            assign txready = 1'b1;
            assign txdone  = 1'b0;
            assign dataout = '0;
            assign maskn   = 1'b0;
            assign reqout  = 1'b0;
            assign busy    = 1'b0;

        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cm0_dap_cdc_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cm0_dap_cdc_req_ctrl
// Description : Self-checking bench for cm0_dap_cdc_req_ctrl: vector table for
//               a single transfer plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cm0_dap_cdc_req_ctrl;

    logic        clk;
    logic        reset;
    logic        txvalid;
    logic [31:0] txdata;
    logic        ackin;

    logic        txready, txdone, maskn, reqout, busy;
    logic [31:0] dataout;
    logic        p0_txready, p0_txdone, p0_maskn, p0_reqout, p0_busy;
    logic [31:0] p0_dataout;

    int          checks;
    int          failures;
    logic [31:0] prev_d;

    cm0_dap_cdc_req_ctrl #(.DW(32), .SYNC_STAGES(2), .PRESENT(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .txvalid (txvalid),
        .txdata  (txdata),
        .txready (txready),
        .txdone  (txdone),
        .dataout (dataout),
        .maskn   (maskn),
        .reqout  (reqout),
        .ackin   (ackin),
        .busy    (busy)
    );

    cm0_dap_cdc_req_ctrl #(.DW(32), .SYNC_STAGES(2), .PRESENT(0)) dut_absent (
        .clk     (clk),
        .reset   (reset),
        .txvalid (txvalid),
        .txdata  (txdata),
        .txready (p0_txready),
        .txdone  (p0_txdone),
        .dataout (p0_dataout),
        .maskn   (p0_maskn),
        .reqout  (p0_reqout),
        .ackin   (ackin),
        .busy    (p0_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [31:0] d;
        logic        ack;
        logic        rdy;
        logic        req;
        logic        msk;
        logic        done;
        logic        bsy;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic tv, input logic [31:0] d, input logic ack,
                                input logic rdy, input logic req, input logic msk,
                                input logic done, input logic bsy, input logic [31:0] dout);
        vec_t v;
        v.tv = tv; v.d = d; v.ack = ack; v.rdy = rdy; v.req = req;
        v.msk = msk; v.done = done; v.bsy = bsy; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge; while the mask is open the payload
    // must not have moved since the previous falling edge.
    task automatic tick();
        @(negedge clk);
        if (!reset && maskn) chk("mask_stable", dataout, prev_d);
        prev_d = dataout;
    endtask

    task automatic send(input logic [31:0] d, input bit drop);
        int n;
        n = 0;
        txdata  = d;
        txvalid = 1'b1;
        while (!txready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_ready", txready, 1);
        tick();
        if (drop) txvalid = 1'b0;
        chk("accept_data", dataout, d);
        chk("accept_busy", busy, 1);
        chk("accept_rdy_low", txready, 0);
    endtask

    task automatic handshake(input int d1, input int d2);
        int n;
        n = 0;
        while (!reqout && n < 20) begin tick(); n++; end
        chk("req_rise", reqout, 1);
        chk("mask_eq_req", maskn, reqout);
        chk("busy_rdy_low", txready, 0);
        repeat (d1) tick();
        ackin = 1'b1;
        n = 0;
        while (reqout && n < 20) begin tick(); n++; end
        chk("req_fall", reqout, 0);
        chk("mask_fall", maskn, 0);
        repeat (d2) tick();
        ackin = 1'b0;
        n = 0;
        while (!txdone && n < 20) begin tick(); n++; end
        chk("txdone", txdone, 1);
    endtask

    localparam logic [31:0] c_d = 32'hA5A5_0F0F;
    localparam logic [31:0] c_x = 32'h1234_5678;

    initial begin
        checks   = 0;
        failures = 0;
        prev_d   = '0;
        reset    = 1'b1;
        txvalid  = 1'b0;
        txdata   = '0;
        ackin    = 1'b0;

        //                tv    d    ack  rdy  req  msk  done bsy  dout
        vecs[0]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, c_d,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[3]  = mk(1'b0, c_d,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_d);
        vecs[4]  = mk(1'b0, c_d,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_d);
        vecs[5]  = mk(1'b1, c_x,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_d);
        vecs[6]  = mk(1'b0, c_x,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_d);
        vecs[7]  = mk(1'b0, c_x,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_d);
        vecs[8]  = mk(1'b0, c_x,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[9]  = mk(1'b0, c_x,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[10] = mk(1'b0, c_x,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[11] = mk(1'b0, c_x,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[12] = mk(1'b0, c_x,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d);
        vecs[13] = mk(1'b0, c_x,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_d);
        vecs[14] = mk(1'b0, c_x,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_d);

        // Reset state
        repeat (3) tick();
        chk("rst_dataout", dataout, 0);
        chk("rst_maskn", maskn, 0);
        chk("rst_reqout", reqout, 0);
        chk("rst_txdone", txdone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txready", txready, 0);
        reset = 1'b0;

        // Single transfer from the vector table
        for (int i = 0; i < 15; i++) begin
            txvalid = vecs[i].tv;
            txdata  = vecs[i].d;
            ackin   = vecs[i].ack;
            tick();
            chk($sformatf("v%0d_txready", i), txready, vecs[i].rdy);
            chk($sformatf("v%0d_reqout", i),  reqout,  vecs[i].req);
            chk($sformatf("v%0d_maskn", i),   maskn,   vecs[i].msk);
            chk($sformatf("v%0d_txdone", i),  txdone,  vecs[i].done);
            chk($sformatf("v%0d_busy", i),    busy,    vecs[i].bsy);
            chk($sformatf("v%0d_dataout", i), dataout, vecs[i].dout);
        end

        // TXVALID held high with 1,2,3: back-to-back handshakes
        for (int k = 1; k <= 3; k++) begin
            send(32'(k), 1'b0);
            txdata = 32'(k + 1);
            handshake(1, 1);
            if (k == 3) txvalid = 1'b0;
            chk("b2b_ready", txready, 1);
            chk("b2b_data", dataout, 32'(k));
        end

        // Stale ACK held high across a source reset
        ackin   = 1'b1;
        txvalid = 1'b1;
        txdata  = 32'h0000_0055;
        #2 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stale_rdy", txready, 0);
            chk("stale_req", reqout, 0);
        end
        ackin = 1'b0;
        tick();
        chk("stale_rdy_e1", txready, 0);
        tick();
        chk("stale_rdy_e2", txready, 1);
        chk("stale_req_e2", reqout, 0);
        send(32'h0000_0055, 1'b1);
        handshake(2, 2);

        // Asynchronous reset while REQ is up
        send(32'hDEAD_BEEF, 1'b1);
        for (int n = 0; n < 10 && !reqout; n++) tick();
        chk("rreq_maskn_up", maskn, 1);
        #2 reset = 1'b1;
        #1;
        chk("rreq_maskn", maskn, 0);
        chk("rreq_reqout", reqout, 0);
        chk("rreq_dataout", dataout, 0);
        chk("rreq_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        send(32'h0BAD_F00D, 1'b1);
        handshake(0, 0);
        chk("rreq_next_data", dataout, 32'h0BAD_F00D);

        // Random transfers with random ACK delays; mask ordering checked in tick()
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (d == dataout) d = ~d;
            send(d, 1'b1);
            handshake(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // Absent block: constant outputs whatever the inputs do
        txvalid = 1'b1;
        txdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            ackin = ~ackin;
            tick();
            chk("abs_txready", p0_txready, 1);
            chk("abs_txdone", p0_txdone, 0);
            chk("abs_dataout", p0_dataout, 0);
            chk("abs_maskn", p0_maskn, 0);
            chk("abs_reqout", p0_reqout, 0);
            chk("abs_busy", p0_busy, 0);
        end
        txvalid = 1'b0;
        ackin   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
